interrupt_ctrl: RTL and testbench
=================================

# interrupt_ctrl

Interrupt and reset sequencer sitting upstream of the CPU datapath. It synchronizes the external `irq_b` and `nmi_b` pins and detects the NMI falling edge. At each instruction boundary it decides whether the microcode controller must run the interrupt sequence instead of the next opcode. During the vector fetch it supplies the vector low/high bytes on the datapath `constant` bus, along with the B-flag value for the pushed status byte.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `irq_b` and `nmi_b`; legal values are 2 and 3.

Ports:
- `ph2` in 1: the only clock; every flop updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `irq_b` in 1: asynchronous, active-low, level-sensitive interrupt request.
- `nmi_b` in 1: asynchronous, active-low, falling-edge-sensitive non-maskable interrupt.
- `i_flag` in 1: interrupt-disable bit, taken from datapath `p_s1[2]`.
- `fetch_boundary` in 1: one-cycle pulse from the controller at the cycle in which it would begin the next opcode fetch.
- `vec_fetch_lo` in 1: the controller is loading the vector low byte.
- `vec_fetch_hi` in 1: the controller is loading the vector high byte.
- `int_done` in 1: one-cycle pulse from the controller when the vector high byte has been consumed.
- `take_int` out 1: the controller must run the interrupt sequence and suppress the opcode.
- `vector_constant` out 8: vector byte.
- `vector_constant_en` out 1: drives the datapath `constant_en`.
- `pushed_b` out 1: B bit for the pushed P byte. Always 0, because this block services only hardware sources.
- `int_src` out 2: current or last serviced source.

## Operation

States: RUN and SERVICE.

Reset:
- On `reset`, state becomes SERVICE, `int_src` becomes SRC_RST, and `take_int` becomes 1.
- `nmi_pend` clears to 0.
- All synchronizer flops and the NMI edge flop load 1 (inactive).

NMI detection:
- NMI is detected as synchronized `nmi_b` going from 1 to 0.
- A detected edge sets `nmi_pend`, which stays set until an NMI is accepted or hijacks a service.
- An edge detected while an NMI is already in service re-sets `nmi_pend`, so a second NMI is serviced afterwards.

IRQ qualification:
- IRQ is qualified as synchronized `irq_b == 0` and `i_flag == 0`.
- The IRQ request is not latched; if it is released before a boundary, it is not taken.

Transitions:
- RUN to SERVICE happens on `fetch_boundary` when `nmi_pend` is set or IRQ is qualified.
  - Priority is NMI over IRQ.
  - `int_src` is set to SRC_NMI or SRC_IRQ.
  - Accepting an NMI clears `nmi_pend`.
- `fetch_boundary` is ignored in SERVICE.
- SERVICE to RUN happens on `int_done`. If a source is pending in that same cycle, it is not accepted until the next `fetch_boundary`.

NMI hijack:
- Applies in SERVICE with `int_src == SRC_IRQ`, while `nmi_pend` is set and `vec_fetch_lo` has not yet been asserted in this service.
- When it applies, `int_src` switches to SRC_NMI and `nmi_pend` clears.
- Once `vec_fetch_lo` has been seen, `int_src` is frozen until `int_done`.

Vector bytes:
- Low byte by source:
  - SRC_NMI gives 8'hFA.
  - SRC_RST gives 8'hFC.
  - SRC_IRQ gives 8'hFE.
- The high byte is always 8'hFF.
- `vector_constant` is the low byte while `vec_fetch_lo` is 1, the high byte while `vec_fetch_hi` is 1, and 8'h00 otherwise.
- `vector_constant_en = vec_fetch_lo | vec_fetch_hi`.
- `vec_fetch_lo` and `vec_fetch_hi` asserted together is illegal; the low byte wins.

## Timing

- Input to synchronized value takes `SYNC_STAGES` cycles.
- The NMI edge is visible in `nmi_pend` one cycle later than the synchronized value.
- `take_int` and `int_src` are registered. They change at the edge following the `fetch_boundary` or `int_done` cycle.
- `vector_constant`, `vector_constant_en` and `pushed_b` are combinational from registered state and the strobes, with zero latency within the same cycle.
- A hijack updates `int_src` at the edge after `nmi_pend` becomes visible. It must be complete before the `vec_fetch_lo` cycle in order to take effect.
- Reset values of the outputs:
  - `take_int` = 1
  - `int_src` = SRC_RST
  - `vector_constant` = 8'h00
  - `vector_constant_en` = 0
  - `pushed_b` = 0
- A `reset` asserted mid-service aborts the service and restarts as described under reset; any pending NMI is lost.

## Structure

- Package `intr_pkg` holds:
  - the enum `int_src_t` {SRC_NONE=0, SRC_RST, SRC_NMI, SRC_IRQ}
  - `VEC_NMI_LO` = 8'hFA, `VEC_RST_LO` = 8'hFC, `VEC_IRQ_LO` = 8'hFE, `VEC_HI` = 8'hFF
  - the state enum {RUN, SERVICE}
- Sub-module `sync_chain` is a parameterized N-stage synchronizer with a reset value of 1. It is instantiated once each for `irq_b` and `nmi_b`.

## Test plan

- **Reset:** hold `reset` for 2 cycles, then pulse `vec_fetch_lo` and then `vec_fetch_hi`.
  - Required: FC then FF with `vector_constant_en` = 1, and `take_int` = 1 until `int_done`, then 0.
- **Masked IRQ:** set `irq_b` = 0 with `i_flag` = 1, then pulse `fetch_boundary`.
  - Required: `take_int` stays 0.
  - Then clear `i_flag` and pulse `fetch_boundary` again. Required: `take_int` = 1 next cycle, `int_src` = SRC_IRQ, low byte FE.
- **NMI edge with IRQ present:** pulse `nmi_b` low for 1 cycle while `irq_b` = 0, then wait 4 cycles and pulse `fetch_boundary`.
  - Required: `int_src` = SRC_NMI, low byte FA.
  - Also required: the IRQ is accepted at the first boundary after `int_done`, provided `i_flag` is still 0.
- **Hijack:** accept an IRQ, then pulse `nmi_b` low before `vec_fetch_lo`.
  - Required: low byte FA and `nmi_pend` cleared.
  - Repeat with the NMI edge after `vec_fetch_lo`. Required: FE/FF is completed, then NMI is taken at the next boundary.
- **Second NMI:** produce an NMI edge during NMI service.
  - Required: a second service with FA after `int_done`.
  - Also required: `int_done` coinciding with `fetch_boundary` does not accept the new source until the next `fetch_boundary` after `int_done`.
- **Mid-service reset:** assert `reset` during an IRQ service with `nmi_pend` set.
  - Required: `int_src` = SRC_RST, `nmi_pend` = 0, and the next vector fetch gives FC.

Source files
------------

// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : intr_pkg
//  Description : Shared types and constants for the interrupt/reset sequencer:
//                interrupt source encoding, vector bytes, sequencer states.
//  Revision    : 1.0 - initial release
// ============================================================================
package intr_pkg;

    // Source currently (or most recently) being serviced
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RST  = 2'd1,
        SRC_NMI  = 2'd2,
        SRC_IRQ  = 2'd3
    } int_src_t;

    // Vector bytes placed on the datapath constant bus during the vector fetch
    localparam logic [7:0] VEC_NMI_LO = 8'hFA;
    localparam logic [7:0] VEC_RST_LO = 8'hFC;
    localparam logic [7:0] VEC_IRQ_LO = 8'hFE;
    localparam logic [7:0] VEC_HI     = 8'hFF;

    // Sequencer states: executing opcodes, or running the interrupt sequence
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        SERVICE = 1'b1
    } state_t;

    // Low vector byte for a given source; SRC_NONE never reaches a vector fetch
    function automatic logic [7:0] vec_lo_byte(input int_src_t src);
        logic [7:0] v;
        case (src)
            SRC_NMI: v = VEC_NMI_LO;
            SRC_RST: v = VEC_RST_LO;
            SRC_IRQ: v = VEC_IRQ_LO;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : N-stage flop synchronizer for an asynchronous active-low pin.
//                All stages reset to 1 so the pin reads as inactive.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_sync;

    // Shift the pin through the chain; oldest sample is the synchronized value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/interrupt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_ctrl
//  Description : Interrupt and reset sequencer. Synchronizes irq_b/nmi_b,
//                latches NMI falling edges, decides at each instruction
//                boundary whether to run the interrupt sequence, and drives
//                the vector bytes and pushed B flag during the vector fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_ctrl
    import intr_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       ph2,
    input  logic       reset,
    input  logic       irq_b,
    input  logic       nmi_b,
    input  logic       i_flag,
    input  logic       fetch_boundary,
    input  logic       vec_fetch_lo,
    input  logic       vec_fetch_hi,
    input  logic       int_done,
    output logic       take_int,
    output logic [7:0] vector_constant,
    output logic       vector_constant_en,
    output logic       pushed_b,
    output logic [1:0] int_src
);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic w_irq_sync;
    logic w_nmi_sync;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync_irq (
        .clk     (ph2),
        .rst     (reset),
        .i_async (irq_b),
        .o_sync  (w_irq_sync)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync_nmi (
        .clk     (ph2),
        .rst     (reset),
        .i_async (nmi_b),
        .o_sync  (w_nmi_sync)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t   r_state;
    state_t   w_state_next;
    int_src_t r_int_src;
    int_src_t w_src_next;
    logic     r_nmi_pend;
    logic     w_pend_next;
    logic     r_lo_seen;       // vec_fetch_lo already seen in this service
    logic     w_lo_seen_next;
    logic     r_nmi_prev;      // synchronized nmi_b one cycle earlier

    logic     w_nmi_edge;
    logic     w_irq_qual;
    logic     w_hijack;

    assign w_nmi_edge = r_nmi_prev & ~w_nmi_sync;
    assign w_irq_qual = ~w_irq_sync & ~i_flag;

    // An NMI may take over an IRQ service only until the low vector byte is read
    assign w_hijack = (r_int_src == SRC_IRQ) & r_nmi_pend & ~r_lo_seen & ~vec_fetch_lo;

    // Register update; reset forces a reset-vector service and drops any NMI
    always_ff @(posedge ph2) begin
        if (reset) begin
            r_state    <= SERVICE;
            r_int_src  <= SRC_RST;
            r_nmi_pend <= 1'b0;
            r_lo_seen  <= 1'b0;
            r_nmi_prev <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_int_src  <= w_src_next;
            r_nmi_pend <= w_pend_next;
            r_lo_seen  <= w_lo_seen_next;
            r_nmi_prev <= w_nmi_sync;
        end
    end

    // Next-state: accept at boundaries, hijack, complete on int_done, latch NMI edges
    always_comb begin
        w_state_next   = r_state;
        w_src_next     = r_int_src;
        w_pend_next    = r_nmi_pend;
        w_lo_seen_next = r_lo_seen;

        case (r_state)
            RUN: begin
                if (fetch_boundary && (r_nmi_pend || w_irq_qual)) begin
                    w_state_next   = SERVICE;
                    w_lo_seen_next = 1'b0;
                    if (r_nmi_pend) begin
                        w_src_next  = SRC_NMI;
                        w_pend_next = 1'b0;
                    end else begin
                        w_src_next  = SRC_IRQ;
                    end
                end
            end
            SERVICE: begin
                if (int_done) begin
                    // Anything pending waits for the next fetch_boundary
                    w_state_next   = RUN;
                    w_lo_seen_next = 1'b0;
                end else begin
                    if (w_hijack) begin
                        w_src_next  = SRC_NMI;
                        w_pend_next = 1'b0;
                    end
                    if (vec_fetch_lo) begin
                        w_lo_seen_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase

        // A fresh edge always re-arms the request, even during NMI service
        if (w_nmi_edge) begin
            w_pend_next = 1'b1;
        end
    end

    // Vector byte mux; low byte wins if both strobes are (illegally) set
    always_comb begin
        vector_constant = 8'h00;
        if (vec_fetch_lo) begin
            vector_constant = vec_lo_byte(r_int_src);
        end else if (vec_fetch_hi) begin
            vector_constant = VEC_HI;
        end
    end

    assign vector_constant_en = vec_fetch_lo | vec_fetch_hi;
    assign pushed_b           = 1'b0;
    assign take_int           = (r_state == SERVICE);
    assign int_src            = r_int_src;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_ctrl
//  Description : Self-checking bench for interrupt_ctrl: directed scenarios
//                with literal expectations followed by random pin/strobe
//                traffic compared each cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_ctrl;

    localparam int S = 2;

    logic       ph2 = 1'b0;
    logic       reset = 1'b1;
    logic       irq_b = 1'b1;
    logic       nmi_b = 1'b1;
    logic       i_flag = 1'b0;
    logic       fetch_boundary = 1'b0;
    logic       vec_fetch_lo = 1'b0;
    logic       vec_fetch_hi = 1'b0;
    logic       int_done = 1'b0;
    logic       take_int;
    logic [7:0] vector_constant;
    logic       vector_constant_en;
    logic       pushed_b;
    logic [1:0] int_src;

    interrupt_ctrl #(.SYNC_STAGES(S)) dut (
        .ph2                (ph2),
        .reset              (reset),
        .irq_b              (irq_b),
        .nmi_b              (nmi_b),
        .i_flag             (i_flag),
        .fetch_boundary     (fetch_boundary),
        .vec_fetch_lo       (vec_fetch_lo),
        .vec_fetch_hi       (vec_fetch_hi),
        .int_done           (int_done),
        .take_int           (take_int),
        .vector_constant    (vector_constant),
        .vector_constant_en (vector_constant_en),
        .pushed_b           (pushed_b),
        .int_src            (int_src)
    );

    always #5 ph2 = ~ph2;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // ------------------------------------------------------------------
    // Behavioural model: pin histories plus the architectural state
    // ------------------------------------------------------------------
    bit       m_take;
    int       m_src;
    bit       m_pend;
    bit       m_lo_seen;
    bit       nmi_hist [0:S];    // nmi_hist[i] = nmi_b sampled i edges ago
    bit       irq_hist [0:S-1];
    bit       m_edge, m_irq_q, m_pend_old;

    function automatic logic [7:0] lo_of(input int src);
        case (src)
            2: return 8'hFA;
            1: return 8'hFC;
            3: return 8'hFE;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge ph2) begin
        if (reset) begin
            m_take    = 1'b1;
            m_src     = 1;
            m_pend    = 1'b0;
            m_lo_seen = 1'b0;
            for (int i = 0; i <= S; i++) nmi_hist[i] = 1'b1;
            for (int i = 0; i < S; i++)  irq_hist[i] = 1'b1;
        end else begin
            m_edge     = nmi_hist[S] && !nmi_hist[S-1];
            m_irq_q    = !irq_hist[S-1] && !i_flag;
            m_pend_old = m_pend;
            if (!m_take) begin
                if (fetch_boundary && (m_pend_old || m_irq_q)) begin
                    m_take    = 1'b1;
                    m_lo_seen = 1'b0;
                    if (m_pend_old) begin
                        m_src  = 2;
                        m_pend = 1'b0;
                    end else begin
                        m_src  = 3;
                    end
                end
            end else if (int_done) begin
                m_take    = 1'b0;
                m_lo_seen = 1'b0;
            end else begin
                if (m_src == 3 && m_pend_old && !m_lo_seen && !vec_fetch_lo) begin
                    m_src  = 2;
                    m_pend = 1'b0;
                end
                if (vec_fetch_lo) m_lo_seen = 1'b1;
            end
            if (m_edge) m_pend = 1'b1;
            for (int i = S; i > 0; i--) nmi_hist[i] = nmi_hist[i-1];
            nmi_hist[0] = nmi_b;
            for (int i = S-1; i > 0; i--) irq_hist[i] = irq_hist[i-1];
            irq_hist[0] = irq_b;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge ph2) begin
        logic [7:0] exp_vc;
        if (chk_en) begin
            exp_vc = vec_fetch_lo ? lo_of(m_src) : (vec_fetch_hi ? 8'hFF : 8'h00);
            n_vec++;
            if (take_int !== m_take) begin
                n_err++;
                $display("FAIL take_int t=%0t got %b want %b", $time, take_int, m_take);
            end
            if (int_src !== 2'(m_src)) begin
                n_err++;
                $display("FAIL int_src t=%0t got %0d want %0d", $time, int_src, m_src);
            end
            if (vector_constant !== exp_vc) begin
                n_err++;
                $display("FAIL vector_constant t=%0t got %h want %h", $time, vector_constant, exp_vc);
            end
            if (vector_constant_en !== (vec_fetch_lo | vec_fetch_hi)) begin
                n_err++;
                $display("FAIL vector_constant_en t=%0t got %b want %b", $time,
                         vector_constant_en, vec_fetch_lo | vec_fetch_hi);
            end
            if (pushed_b !== 1'b0) begin
                n_err++;
                $display("FAIL pushed_b t=%0t got %b want 0", $time, pushed_b);
            end
            if (dut.r_nmi_pend !== m_pend) begin
                n_err++;
                $display("FAIL nmi_pend t=%0t got %b want %b", $time, dut.r_nmi_pend, m_pend);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge ph2);
        #1;
    endtask

    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic nmi_pulse();
        nmi_b = 1'b0;
        cyc();
        nmi_b = 1'b1;
        repeat (4) cyc();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset and reset-vector fetch
        cyc();
        chk_en = 1'b1;
        cyc();
        reset = 1'b0;
        #1 lit("rst_take", 8'(take_int), 8'h01);
        lit("rst_src", 8'(int_src), 8'h01);
        vec_fetch_lo = 1'b1;
        #1 lit("rst_lo", vector_constant, 8'hFC);
        lit("rst_lo_en", 8'(vector_constant_en), 8'h01);
        cyc(); vec_fetch_lo = 1'b0; vec_fetch_hi = 1'b1;
        #1 lit("rst_hi", vector_constant, 8'hFF);
        cyc(); vec_fetch_hi = 1'b0; int_done = 1'b1;
        cyc(); int_done = 1'b0;
        #1 lit("rst_done_take", 8'(take_int), 8'h00);
        lit("idle_vc", vector_constant, 8'h00);

        // Masked IRQ, then unmasked
        irq_b = 1'b0; i_flag = 1'b1;
        repeat (4) cyc();
        fetch_boundary = 1'b1;
        cyc(); fetch_boundary = 1'b0;
        #1 lit("masked_take", 8'(take_int), 8'h00);
        i_flag = 1'b0; fetch_boundary = 1'b1;
        cyc(); fetch_boundary = 1'b0;
        #1 lit("irq_take", 8'(take_int), 8'h01);
        lit("irq_src", 8'(int_src), 8'h03);
        vec_fetch_lo = 1'b1;
        #1 lit("irq_lo", vector_constant, 8'hFE);
        cyc(); vec_fetch_lo = 1'b0; vec_fetch_hi = 1'b1;
        cyc(); vec_fetch_hi = 1'b0; int_done = 1'b1;
        cyc(); int_done = 1'b0;

        // NMI edge while IRQ is asserted: NMI first, IRQ afterwards
        nmi_pulse();
        fetch_boundary = 1'b1;
        cyc(); fetch_boundary = 1'b0;
        #1 lit("nmi_src", 8'(int_src), 8'h02);
        vec_fetch_lo = 1'b1;
        #1 lit("nmi_lo", vector_constant, 8'hFA);
        cyc(); vec_fetch_lo = 1'b0; int_done = 1'b1;
        cyc(); int_done = 1'b0; fetch_boundary = 1'b1;
        cyc(); fetch_boundary = 1'b0;
        #1 lit("irq_after_nmi_src", 8'(int_src), 8'h03);

        // Hijack of the IRQ service before its low vector fetch
        nmi_pulse();
        #1 lit("hijack_src", 8'(int_src), 8'h02);
        lit("hijack_pend", 8'(dut.r_nmi_pend), 8'h00);
        vec_fetch_lo = 1'b1;
        #1 lit("hijack_lo", vector_constant, 8'hFA);
        cyc(); vec_fetch_lo = 1'b0; int_done = 1'b1; irq_b = 1'b1;
        cyc(); int_done = 1'b0;
        repeat (3) cyc();

        // Second NMI during NMI service, with int_done coinciding with a boundary
        nmi_pulse();
        fetch_boundary = 1'b1;
        cyc(); fetch_boundary = 1'b0;
        nmi_pulse();
        #1 lit("nmi2_pend", 8'(dut.r_nmi_pend), 8'h01);
        int_done = 1'b1; fetch_boundary = 1'b1;
        cyc(); int_done = 1'b0; fetch_boundary = 1'b0;
        #1 lit("done_boundary_take", 8'(take_int), 8'h00);
        cyc(); fetch_boundary = 1'b1;
        cyc(); fetch_boundary = 1'b0;
        #1 lit("nmi2_src", 8'(int_src), 8'h02);
        vec_fetch_lo = 1'b1;
        #1 lit("nmi2_lo", vector_constant, 8'hFA);
        cyc(); vec_fetch_lo = 1'b0; int_done = 1'b1;
        cyc(); int_done = 1'b0;

        // Mid-service reset with an NMI pending after the low fetch
        irq_b = 1'b0;
        repeat (3) cyc();
        fetch_boundary = 1'b1;
        cyc(); fetch_boundary = 1'b0; vec_fetch_lo = 1'b1;
        cyc(); vec_fetch_lo = 1'b0;
        nmi_pulse();
        #1 lit("late_nmi_src", 8'(int_src), 8'h03);
        lit("late_nmi_pend", 8'(dut.r_nmi_pend), 8'h01);
        reset = 1'b1;
        cyc(); reset = 1'b0;
        #1 lit("midrst_src", 8'(int_src), 8'h01);
        lit("midrst_pend", 8'(dut.r_nmi_pend), 8'h00);
        vec_fetch_lo = 1'b1;
        #1 lit("midrst_lo", vector_constant, 8'hFC);
        cyc(); vec_fetch_lo = 1'b0; int_done = 1'b1;
        cyc(); int_done = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int r;
            reset          = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) irq_b  = ~irq_b;
            if ($urandom_range(0, 14) == 0) nmi_b  = ~nmi_b;
            if ($urandom_range(0, 29) == 0) i_flag = ~i_flag;
            fetch_boundary = ($urandom_range(0, 5) == 0);
            int_done       = ($urandom_range(0, 11) == 0);
            r = $urandom_range(0, 19);
            vec_fetch_lo   = (r < 3) || (r == 19);
            vec_fetch_hi   = (r >= 3 && r < 6) || (r == 19);
            cyc();
        end
        reset = 1'b0; fetch_boundary = 1'b0; int_done = 1'b0;
        vec_fetch_lo = 1'b0; vec_fetch_hi = 1'b0;
        cyc();
        @(negedge ph2);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
